// File: rtl/alu_muldiv.sv
// Execute-stage ALU with internal aluop/funct decode and an iterative multiply/divide unit on HI/LO.
// Define ALU_MULDIV_DIV_EN to build the divider; without it div/divu decode as illegal.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       aluop_i,
    input  logic [5:0]       funct_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [3:0]       alucontrol_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             illegal_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Codes 8..15 form the HI/LO class; bit 0 clear selects the signed mult/div variant.
    localparam logic [3:0] C_ADD  = 4'd0,  C_SUB  = 4'd1,  C_AND   = 4'd2,  C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4,  C_NOR  = 4'd5,  C_SLT   = 4'd6,  C_SLTU = 4'd7;
    localparam logic [3:0] C_MULT = 4'd8,  C_MULTU = 4'd9;
    localparam logic [3:0] C_MFHI = 4'd12, C_MFLO = 4'd13, C_MTHI  = 4'd14, C_MTLO = 4'd15;
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [3:0] C_DIV  = 4'd10, C_DIVU = 4'd11;
`endif

    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_ITER = 2'd2, S_FIX = 2'd3;

    logic [3:0] ctl;
    logic       ill;

    always_comb begin
        ctl = C_ADD;
        ill = 1'b0;
        case (aluop_i)
            2'b00: ctl = C_ADD;
            2'b01: ctl = C_SUB;
            2'b11: ctl = C_OR;
            default: begin
                case (funct_i)
                    6'b100000, 6'b100001: ctl = C_ADD;
                    6'b100010, 6'b100011: ctl = C_SUB;
                    6'b100100: ctl = C_AND;
                    6'b100101: ctl = C_OR;
                    6'b100110: ctl = C_XOR;
                    6'b100111: ctl = C_NOR;
                    6'b101010: ctl = C_SLT;
                    6'b101011: ctl = C_SLTU;
                    6'b011000: ctl = C_MULT;
                    6'b011001: ctl = C_MULTU;
`ifdef ALU_MULDIV_DIV_EN
                    6'b011010: ctl = C_DIV;
                    6'b011011: ctl = C_DIVU;
`endif
                    6'b010000: ctl = C_MFHI;
                    6'b010010: ctl = C_MFLO;
                    6'b010001: ctl = C_MTHI;
                    6'b010011: ctl = C_MTLO;
                    default:   ill = 1'b1;
                endcase
            end
        endcase
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_q, neg_d, done_q, done_d;
`ifdef ALU_MULDIV_DIV_EN
    logic             is_div_q, is_div_d, rneg_q, rneg_d, dz_q, dz_d;
`endif

    logic             accept, md_op, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b, step_hi, step_lo, fix_hi, fix_lo;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod_n;

    assign busy_o  = (state_q != S_IDLE);
    assign stall_o = start_i & busy_o & ctl[3];
    assign accept  = start_i & ~stall_o & ~ill;
    assign md_op   = (ctl[3:2] == 2'b10);
    assign sa      = ~ctl[0] & a_i[WIDTH-1];
    assign sb      = ~ctl[0] & b_i[WIDTH-1];
    assign mag_a   = sa ? -a_i : a_i;
    assign mag_b   = sb ? -b_i : b_i;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign prod_n  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH:0] div_sh;
    logic           div_ge;
    assign div_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge = (div_sh >= {1'b0, opnd_q});
`endif

    // One iteration step and the final sign fix-up, shared between mult and div.
    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        fix_hi  = prod_n[2*WIDTH-1:WIDTH];
        fix_lo  = prod_n[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
        if (is_div_q) begin
            step_hi = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
            fix_hi  = rneg_q ? -acc_hi_q : acc_hi_q;
            fix_lo  = dz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept && md_op) begin
                    acc_hi_d = '0;
                    acc_lo_d = mag_a;
                    opnd_d   = mag_b;
                    neg_d    = sa ^ sb;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
`ifdef ALU_MULDIV_DIV_EN
                    is_div_d = ctl[1];
                    rneg_d   = sa;
                    dz_d     = (b_i == '0);
`endif
                end
            end
            S_LOAD, S_ITER: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == LAST) ? S_FIX : S_ITER;
            end
            default: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (accept && ctl == C_MTHI) hi_d = a_i;
        if (accept && ctl == C_MTLO) lo_d = a_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef ALU_MULDIV_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
`endif
        end
    end

    logic [WIDTH-1:0] res;
    always_comb begin
        case (ctl)
            C_ADD:   res = a_i + b_i;
            C_SUB:   res = a_i - b_i;
            C_AND:   res = a_i & b_i;
            C_OR:    res = a_i | b_i;
            C_XOR:   res = a_i ^ b_i;
            C_NOR:   res = ~(a_i | b_i);
            C_SLT:   res = WIDTH'($signed(a_i) < $signed(b_i));
            C_SLTU:  res = WIDTH'(a_i < b_i);
            C_MFHI:  res = hi_q;
            C_MFLO:  res = lo_q;
            default: res = '0;
        endcase
        if (ill) res = '0;
    end

    assign result_o     = res;
    assign zero_o       = (res == '0);
    assign alucontrol_o = ctl;
    assign done_o       = done_q;
    assign illegal_o    = ill;
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU with integrated control decode and an iterative multiply/divide unit holding HI/LO registers. It decodes `aluop`/`funct` internally and executes single-cycle ops combinationally. Multiply and divide run as multi-cycle operations behind a busy/stall handshake. It sits in the datapath where the ALU and its decoder sit today, and adds mult/div/mfhi/mflo/mthi/mtlo support for the multicycle/pipelined core.

## Interface
- `WIDTH`, 32, operand/result width in bits; even, ≥ 4.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `aluop`  in  2  main-decoder ALU op
- `funct`  in  6  instruction funct field
- `start`  in  1  instruction valid in execute this cycle
- `a`, `b`  in  WIDTH  operands (rs, rt/imm)
- `result`  out  WIDTH  ALU / mfhi / mflo result
- `zero`  out  1  `result == 0`
- `alucontrol`  out  4  decoded op code, for observability
- `busy`  out  1  mult/div in progress
- `stall`  out  1  hold the issuing stage
- `done`  out  1  one-cycle pulse when HI/LO are updated
- `illegal`  out  1  unrecognised funct

## Operation
- **aluop decode:** 00→add, 01→sub, 11→or, 10→funct decode.
- **Funct decode:**
  - 100000/100001 → add
  - 100010/100011 → sub
  - 100100 → and
  - 100101 → or
  - 100110 → xor
  - 100111 → nor
  - 101010 → slt (signed)
  - 101011 → sltu
  - 011000/011001 → mult/multu
  - 011010/011011 → div/divu
  - 010000 → mfhi
  - 010010 → mflo
  - 010001 → mthi
  - 010011 → mtlo
  - any other funct → `illegal`=1, `result`=0.
- **Combinational outputs:** `illegal` and `alucontrol` are combinational and independent of `start`. slt/sltu give 1 or 0, zero-extended. Add/sub wrap modulo 2^WIDTH, with no overflow trap.
- **Results by op:**
  - mfhi/mflo: `result` = current HI/LO register value.
  - mult/div/mthi/mtlo: `result` = 0.
- **Stall and accept:**
  - `stall` = `start & busy & op ∈ {mult*, div*, mf*, mt*}`.
  - Accept = `start & !stall & !illegal`.
- **mthi/mtlo:** when accepted, write HI or LO from `a` at the clock edge.
- **Mult/div FSM:** states IDLE → LOAD → ITER → FIX → IDLE.
  - LOAD (accept edge): latch the magnitudes of a/b (signed ops) or the raw values (unsigned ops), and latch the result signs.
  - ITER: WIDTH shift-add (mult) or restoring-subtract (div) steps, counter 0..WIDTH-1.
  - FIX: apply signs and write HI/LO.
    - mult: HI:LO = 2·WIDTH-bit product.
    - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- **Divide by zero:** HI = `a`, LO = all-ones. Signed overflow (min / −1): LO = min, HI = 0.
- **Reset:** HI = LO = 0, FSM to IDLE, `busy`/`done` = 0. Reset mid-operation aborts it; HI/LO are zeroed and no `done` is produced.

## Timing
- Single-cycle ops have zero latency: `result`/`zero` are combinational from the inputs.
- Mult/div timeline, with accept at edge E0:
  - `busy` = 1 from after E0 through edge E(WIDTH+1).
  - E1..E(WIDTH) perform the iterations.
  - E(WIDTH+1) is FIX: HI/LO are written and `busy` falls.
  - `done` = 1 for exactly the cycle after E(WIDTH+1).
- An mfhi/mflo issued in the `done` cycle returns the new value without stalling.
- `start` with a hi/lo-class op while busy: `stall` = 1 and the request is ignored; the requester holds `start`/inputs until `stall` falls. Non-hi/lo ALU ops execute normally while busy.
- mthi/mtlo accepted in the `done` cycle overwrites the freshly written value at that edge.
- All outputs are 0 after reset except `zero`, which follows `result`.

## Configuration
- **With `ALU_MULDIV_DIV_EN` defined:** div/divu are implemented as specified above.
- **Without `ALU_MULDIV_DIV_EN`:**
  - funct 011010/011011 decode as illegal: `illegal` = 1, no accept, `busy` stays 0, HI/LO unchanged.
  - The divider datapath is not synthesised.
  - Multiply and all other behaviour are identical.

## Test plan
All scenarios use WIDTH = 32.
- Reset; aluop=10, funct=100010, a=5, b=7 → `result`=0xFFFFFFFE, `zero`=0. Same with a=b=7 → `zero`=1.
- mult a=0xFFFFFFFD (−3), b=7, one-cycle start → `busy` high 33 cycles, single `done` pulse. Then mflo → 0xFFFFFFEB, mfhi → 0xFFFFFFFF. multu with the same operands → HI=6, LO=0xFFFFFFEB.
- divu a=100, b=7 → LO=14, HI=2. div a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div a=9, b=0 → HI=9, LO=0xFFFFFFFF.
- During a mult, hold mflo start → `stall`=1 every cycle until the `done` cycle, then `result` = product low word. A second mult start while busy is ignored (counter not restarted). An add issued while busy executes with `stall`=0.
- Reset asserted at iteration 10 of a mult → next cycle `busy`=0, HI=LO=0, no `done` ever. mthi a=0x1234 then mfhi → 0x1234.
- Build without `ALU_MULDIV_DIV_EN`: funct=011010, start=1 → `illegal`=1, `busy`=0, HI/LO unchanged. funct=111111 in both builds → `illegal`=1, `result`=0.
